vga_window_compositor: RTL and testbench
========================================

Name: vga_window_compositor

Overview:
- Parametrised N-channel successor to the fixed two-quadrant VGA pixel selector.
- Composites NUM_CH rectangular windows, each fed by one SDRAM read FIFO port, onto the VGA active area; fixed lower-index-wins priority.
- Window geometry is runtime-programmable and shadowed per frame. Read strobes are generated in the pixel cycle; returned data and syncs are re-aligned by an internal delay pipeline.
- Sits between the VGA timing controller and the SDRAM 4-port controller read side.

Parameters:
- NUM_CH, 4, number of windows / read ports (1..8)
- CW, 11, coordinate width
- PIX_W, 16, read data width (RGB565)
- COLOR_W, 10, output colour component width (>=6)
- READ_LAT, 1, cycles from oRead high to valid iRD_DATA (1..4)

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  synchronous active-high reset
- iFRAME_START  in  1  one-cycle pulse in vertical blanking; loads shadow config
- iX_ADDR  in  CW  active-area x coordinate
- iY_ADDR  in  CW  active-area y coordinate
- iDE  in  1  active video
- iHS  in  1  hsync, passed through
- iVS  in  1  vsync, passed through
- iWIN_EN  in  NUM_CH  per-window enable
- iWIN_X0, iWIN_Y0, iWIN_W, iWIN_H  in  NUM_CH*CW each  window origin and size; channel k occupies bits [k*CW +: CW]
- iBG_COLOR  in  3*COLOR_W  background colour {R,G,B}
- iRD_DATA  in  NUM_CH*PIX_W  FIFO read data per channel
- iRD_EMPTY  in  NUM_CH  FIFO empty per channel
- iERR_CLR  in  1  clears underflow flags
- oRead  out  NUM_CH  FIFO read strobes
- oRed, oGreen, oBlue  out  COLOR_W each  pixel colour
- oDE, oHS, oVS  out  1 each  delayed timing
- oUNDERFLOW  out  NUM_CH  sticky per-channel underflow flag

Behaviour:
- Reset: shadow config all zero (all windows disabled); delay pipeline cleared; oRead=0, colours=0, oDE=oHS=oVS=0, oUNDERFLOW=0.
- Shadow load: on iFRAME_START, all iWIN_* inputs are captured into shadow registers. Shadow values are used from the next cycle on. Inputs changing mid-frame have no effect.
- hit[k] = iDE & en[k] & (X >= x0[k]) & (X < x0[k]+w[k]) & (Y >= y0[k]) & (Y < y0[k]+h[k]).
  - Sums are computed in CW+1 bits, so there is no wrap.
  - w=0 or h=0 means no hit.
- oRead[k] = hit[k], combinational from the current inputs and shadow state.
  - Every hit channel reads, including occluded ones, so each FIFO consumes exactly w*h words per frame.
- Winner = lowest k with hit[k]; none if no hit.
- Winner index, valid bit, iDE, iHS, iVS and an underflow tag (hit & iRD_EMPTY per channel) are delayed READ_LAT cycles through a shift pipeline.
- At pipeline tap READ_LAT, the winner's iRD_DATA is unpacked:
  - R = DATA[4:0], G = DATA[10:5], B = DATA[15:11].
  - Each component is left-aligned into COLOR_W and zero-filled.
  - The unpacked colour is registered to the outputs.
- Total latency from iX/iY/iDE/iHS/iVS to outputs: READ_LAT+1 cycles, identical for colour and syncs.
- Colour when delayed DE=1 and no winner: iBG_COLOR. When delayed DE=0: 0.
- Underflow:
  - If oRead[k]=1 while iRD_EMPTY[k]=1, oUNDERFLOW[k] sets one cycle later and stays set until iERR_CLR or iRST.
  - The affected output pixel, if that channel is the winner, shows iBG_COLOR.
  - If iERR_CLR and a new underflow occur in the same cycle, set wins.
- iFRAME_START during iDE=1: still loads. Windows may tear; this is the integrator's responsibility.
- Reset mid-line: the pipeline flushes; outputs stay 0 until READ_LAT+1 cycles after release.

Optional Feature:
- Macro: WINDOW_BORDER_EN.
- Defined:
  - A pixel on the outermost row or column of a winning window is displayed as white (all ones).
  - The FIFO is still read for that pixel, and the border test is pipelined with the winner.
- Undefined: no border logic; window pixels are shown unmodified.

Test Plan:
- Reset, then drive a 640x480 raster with no shadow load.
  - Expect oRead=0 throughout.
  - Expect the output to be iBG_COLOR=0x3FF/0/0 during DE and 0 outside DE.
- Shadow load ch0 = (0,0,320,240) and ch1 = (320,0,320,240), READ_LAT=1; drive data 0x001F on ch0 and 0xF800 on ch1.
  - Expect oRead[0] high for X 0..319, Y 0..239.
  - Expect outputs two cycles later: red=0x3E0 in the left half, blue=0x3E0 in the right half.
- Overlap: ch0 = (100,100,50,50), ch2 = (120,120,50,50).
  - At X=Y=130, expect both oRead high and ch0 colour displayed.
  - Per frame, oRead[2] counts 2500.
- Change iWIN_X0 mid-frame without iFRAME_START.
  - Expect the read pattern to be unchanged until the next pulse, then the new pattern.
- Hold iRD_EMPTY[1]=1 inside window 1.
  - Expect oUNDERFLOW[1] set next cycle and the affected pixels shown as background.
  - Pulse iERR_CLR with empty=0: flag clears.
- With WINDOW_BORDER_EN defined, window (10,10,4,4): pixels (10..13,10), (10..13,13), (10,11..12), (13,11..12) are white; (11..12,11..12) show data.

Source files
------------

// File: rtl/vga_window_compositor.sv
// N-window compositor: shadowed per-frame window geometry, FIFO read strobes in the pixel
// cycle, and data/syncs realigned READ_LAT+1 cycles later. Optional macro: WINDOW_BORDER_EN.
module vga_window_compositor #(
    parameter int NUM_CH   = 4,
    parameter int CW       = 11,
    parameter int PIX_W    = 16,
    parameter int COLOR_W  = 10,
    parameter int READ_LAT = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iFRAME_START,
    input  logic [CW-1:0]         iX_ADDR,
    input  logic [CW-1:0]         iY_ADDR,
    input  logic                  iDE,
    input  logic                  iHS,
    input  logic                  iVS,
    input  logic [NUM_CH-1:0]     iWIN_EN,
    input  logic [NUM_CH*CW-1:0]  iWIN_X0,
    input  logic [NUM_CH*CW-1:0]  iWIN_Y0,
    input  logic [NUM_CH*CW-1:0]  iWIN_W,
    input  logic [NUM_CH*CW-1:0]  iWIN_H,
    input  logic [3*COLOR_W-1:0]  iBG_COLOR,
    input  logic [NUM_CH*PIX_W-1:0] iRD_DATA,
    input  logic [NUM_CH-1:0]     iRD_EMPTY,
    input  logic                  iERR_CLR,
    output logic [NUM_CH-1:0]     oRead,
    output logic [COLOR_W-1:0]    oRed,
    output logic [COLOR_W-1:0]    oGreen,
    output logic [COLOR_W-1:0]    oBlue,
    output logic                  oDE,
    output logic                  oHS,
    output logic                  oVS,
    output logic [NUM_CH-1:0]     oUNDERFLOW
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] hit;
`ifdef WINDOW_BORDER_EN
    logic [NUM_CH-1:0] border;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic          en_reg;
            logic [CW-1:0] x0_reg, y0_reg, w_reg, h_reg;
            logic [CW:0]   x_end, y_end;

            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    en_reg <= 1'b0;
                    x0_reg <= '0;
                    y0_reg <= '0;
                    w_reg  <= '0;
                    h_reg  <= '0;
                end else if (iFRAME_START) begin
                    en_reg <= iWIN_EN[gi];
                    x0_reg <= iWIN_X0[gi*CW +: CW];
                    y0_reg <= iWIN_Y0[gi*CW +: CW];
                    w_reg  <= iWIN_W[gi*CW +: CW];
                    h_reg  <= iWIN_H[gi*CW +: CW];
                end
            end

            // One extra bit keeps x0+w from wrapping at the coordinate limit
            assign x_end = {1'b0, x0_reg} + {1'b0, w_reg};
            assign y_end = {1'b0, y0_reg} + {1'b0, h_reg};

            assign hit[gi] = !iRST && iDE && en_reg
                           && (iX_ADDR >= x0_reg) && ({1'b0, iX_ADDR} < x_end)
                           && (iY_ADDR >= y0_reg) && ({1'b0, iY_ADDR} < y_end);

`ifdef WINDOW_BORDER_EN
            assign border[gi] = (iX_ADDR == x0_reg) || ({1'b0, iX_ADDR} == x_end - (CW+1)'(1))
                             || (iY_ADDR == y0_reg) || ({1'b0, iY_ADDR} == y_end - (CW+1)'(1));
`endif
        end
    endgenerate

    // Occluded windows still read so every FIFO drains exactly w*h words per frame
    assign oRead = hit;

    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
`ifdef WINDOW_BORDER_EN
    logic             win_brd;
`endif

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
`ifdef WINDOW_BORDER_EN
        win_brd = 1'b0;
`endif
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(k);
`ifdef WINDOW_BORDER_EN
                win_brd = border[k];
`endif
            end
        end
    end

    logic [IDX_W-1:0]  idx_pipe [READ_LAT];
    logic [NUM_CH-1:0] uf_pipe  [READ_LAT];
    logic [READ_LAT-1:0] vld_pipe, de_pipe, hs_pipe, vs_pipe;
`ifdef WINDOW_BORDER_EN
    logic [READ_LAT-1:0] brd_pipe;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int s = 0; s < READ_LAT; s++) begin
                idx_pipe[s] <= '0;
                uf_pipe[s]  <= '0;
            end
            vld_pipe <= '0;
            de_pipe  <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
`ifdef WINDOW_BORDER_EN
            brd_pipe <= '0;
`endif
        end else begin
            for (int s = READ_LAT - 1; s > 0; s--) begin
                idx_pipe[s] <= idx_pipe[s-1];
                uf_pipe[s]  <= uf_pipe[s-1];
                vld_pipe[s] <= vld_pipe[s-1];
                de_pipe[s]  <= de_pipe[s-1];
                hs_pipe[s]  <= hs_pipe[s-1];
                vs_pipe[s]  <= vs_pipe[s-1];
`ifdef WINDOW_BORDER_EN
                brd_pipe[s] <= brd_pipe[s-1];
`endif
            end
            idx_pipe[0] <= win_idx;
            uf_pipe[0]  <= hit & iRD_EMPTY;
            vld_pipe[0] <= win_vld;
            de_pipe[0]  <= iDE;
            hs_pipe[0]  <= iHS;
            vs_pipe[0]  <= iVS;
`ifdef WINDOW_BORDER_EN
            brd_pipe[0] <= win_brd;
`endif
        end
    end

    logic [IDX_W-1:0] tap_idx;
    logic [PIX_W-1:0] tap_data;
    logic             tap_uf;
    logic [COLOR_W-1:0] red_next, green_next, blue_next;

    assign tap_idx = idx_pipe[READ_LAT-1];
    assign tap_uf  = uf_pipe[READ_LAT-1][tap_idx];

    always_comb begin
        tap_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (tap_idx == IDX_W'(k)) tap_data = iRD_DATA[k*PIX_W +: PIX_W];
        end
    end

    // RGB565 stored R in the low bits; components are MSB-aligned and zero-filled
    always_comb begin
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;
        if (de_pipe[READ_LAT-1]) begin
            if (!vld_pipe[READ_LAT-1] || tap_uf) begin
                red_next   = iBG_COLOR[3*COLOR_W-1 -: COLOR_W];
                green_next = iBG_COLOR[2*COLOR_W-1 -: COLOR_W];
                blue_next  = iBG_COLOR[COLOR_W-1:0];
`ifdef WINDOW_BORDER_EN
            end else if (brd_pipe[READ_LAT-1]) begin
                red_next   = '1;
                green_next = '1;
                blue_next  = '1;
`endif
            end else begin
                red_next   = COLOR_W'(tap_data[4:0])   << (COLOR_W - 5);
                green_next = COLOR_W'(tap_data[10:5])  << (COLOR_W - 6);
                blue_next  = COLOR_W'(tap_data[15:11]) << (COLOR_W - 5);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
            oDE        <= 1'b0;
            oHS        <= 1'b0;
            oVS        <= 1'b0;
            oUNDERFLOW <= '0;
        end else begin
            oRed       <= red_next;
            oGreen     <= green_next;
            oBlue      <= blue_next;
            oDE        <= de_pipe[READ_LAT-1];
            oHS        <= hs_pipe[READ_LAT-1];
            oVS        <= vs_pipe[READ_LAT-1];
            // A fresh underflow outranks a simultaneous clear
            oUNDERFLOW <= (oUNDERFLOW & ~{NUM_CH{iERR_CLR}}) | (hit & iRD_EMPTY);
        end
    end

endmodule

// File: tb/tb_vga_window_compositor.sv
// Directed bench for vga_window_compositor (NUM_CH=4, READ_LAT=1): drives raster fragments
// and checks reads, composited colour, delayed syncs and underflow flags.
module tb_vga_window_compositor;

    localparam int NUM_CH = 4, CW = 11, PIX_W = 16, COLOR_W = 10, READ_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    iRST, iFRAME_START, iDE, iHS, iVS, iERR_CLR;
    logic [CW-1:0]           iX_ADDR, iY_ADDR;
    logic [NUM_CH-1:0]       iWIN_EN, iRD_EMPTY;
    logic [NUM_CH*CW-1:0]    iWIN_X0, iWIN_Y0, iWIN_W, iWIN_H;
    logic [3*COLOR_W-1:0]    iBG_COLOR;
    logic [NUM_CH*PIX_W-1:0] iRD_DATA;
    logic [NUM_CH-1:0]       oRead, oUNDERFLOW;
    logic [COLOR_W-1:0]      oRed, oGreen, oBlue;
    logic                    oDE, oHS, oVS;

    vga_window_compositor #(
        .NUM_CH(NUM_CH), .CW(CW), .PIX_W(PIX_W), .COLOR_W(COLOR_W), .READ_LAT(READ_LAT)
    ) dut (
        .iCLK(clk), .iRST(iRST), .iFRAME_START(iFRAME_START),
        .iX_ADDR(iX_ADDR), .iY_ADDR(iY_ADDR), .iDE(iDE), .iHS(iHS), .iVS(iVS),
        .iWIN_EN(iWIN_EN), .iWIN_X0(iWIN_X0), .iWIN_Y0(iWIN_Y0), .iWIN_W(iWIN_W), .iWIN_H(iWIN_H),
        .iBG_COLOR(iBG_COLOR), .iRD_DATA(iRD_DATA), .iRD_EMPTY(iRD_EMPTY), .iERR_CLR(iERR_CLR),
        .oRead(oRead), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oDE(oDE), .oHS(oHS), .oVS(oVS), .oUNDERFLOW(oUNDERFLOW)
    );

    int n_vec = 0, n_err = 0;
    int cur_x = 0, cur_y = 0;
    int rd0_cnt = 0, rd2_cnt = 0;

    int tb_en[4], tb_x0[4], tb_y0[4], tb_w[4], tb_h[4];
    int sh_en[4], sh_x0[4], sh_y0[4], sh_w[4], sh_h[4];
    logic [15:0] tb_data[4];
    logic [29:0] exp_col[4];
    logic [29:0] bg;

    logic [3:0]  empty_drv = '0, rd_prev = '0, exp_uf = '0;
    bit          rst_drv = 1'b0, fs_drv = 1'b0, clr_drv = 1'b0, vs_drv = 1'b0, uf_known = 1'b0;
    logic [29:0] hcol[2];
    logic [2:0]  hsync[2];
    bit          hv[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at x=%0d y=%0d: got %h expected %h", tag, cur_x, cur_y, obs, expv);
        end
    endtask

    function automatic void model(input int x, input int y, input bit de,
                                  output logic [3:0] rd, output logic [29:0] col);
        int win;
        win = -1;
        rd  = '0;
        for (int k = 0; k < 4; k++) begin
            if (de && sh_en[k] != 0 && x >= sh_x0[k] && x < sh_x0[k] + sh_w[k]
                && y >= sh_y0[k] && y < sh_y0[k] + sh_h[k]) begin
                rd[k] = 1'b1;
                if (win < 0) win = k;
            end
        end
        if (!de) col = '0;
        else if (win < 0 || empty_drv[win]) col = bg;
`ifdef WINDOW_BORDER_EN
        else if (x == sh_x0[win] || x == sh_x0[win] + sh_w[win] - 1
                 || y == sh_y0[win] || y == sh_y0[win] + sh_h[win] - 1) col = '1;
`endif
        else col = exp_col[win];
    endfunction

    task automatic apply_cfg();
        for (int k = 0; k < 4; k++) begin
            iWIN_EN[k] = (tb_en[k] != 0);
            iWIN_X0[k*CW +: CW] = CW'(tb_x0[k]);
            iWIN_Y0[k*CW +: CW] = CW'(tb_y0[k]);
            iWIN_W[k*CW +: CW]  = CW'(tb_w[k]);
            iWIN_H[k*CW +: CW]  = CW'(tb_h[k]);
        end
    endtask

    // One pixel clock: check outputs due from two steps ago, then drive this pixel
    task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
        logic [3:0]  rd;
        logic [29:0] col;
        @(negedge clk);
        if (uf_known) chk("underflow", 32'(oUNDERFLOW), 32'(exp_uf));
        if (hv[1]) begin
            chk("red",   32'(oRed),   32'(hcol[1][29:20]));
            chk("green", 32'(oGreen), 32'(hcol[1][19:10]));
            chk("blue",  32'(oBlue),  32'(hcol[1][9:0]));
            chk("sync",  32'({oDE, oHS, oVS}), 32'(hsync[1]));
        end
        cur_x = x;
        cur_y = y;
        model(x, y, de, rd, col);
        if (rst_drv) begin
            rd  = '0;
            col = '0;
        end
        hcol[1] = hcol[0]; hsync[1] = hsync[0]; hv[1] = hv[0];
        hcol[0] = col; hsync[0] = rst_drv ? 3'b000 : {de, hs, vs}; hv[0] = 1'b1;
        if (rst_drv) begin
            hcol[1] = '0; hsync[1] = '0; hv[1] = 1'b1; uf_known = 1'b1;
        end
        exp_uf = rst_drv ? 4'b0 : ((exp_uf & ~{4{clr_drv}}) | (rd & empty_drv));
        iRST = rst_drv; iFRAME_START = fs_drv; iERR_CLR = clr_drv;
        iX_ADDR = CW'(x); iY_ADDR = CW'(y); iDE = de; iHS = hs; iVS = vs;
        iRD_EMPTY = empty_drv;
        for (int k = 0; k < 4; k++)
            iRD_DATA[k*PIX_W +: PIX_W] = rd_prev[k] ? tb_data[k] : 16'hAAAA;
        rd_prev = rd;
        for (int k = 0; k < 4; k++) begin
            if (rst_drv) begin
                sh_en[k] = 0; sh_x0[k] = 0; sh_y0[k] = 0; sh_w[k] = 0; sh_h[k] = 0;
            end else if (fs_drv) begin
                sh_en[k] = tb_en[k]; sh_x0[k] = tb_x0[k]; sh_y0[k] = tb_y0[k];
                sh_w[k] = tb_w[k]; sh_h[k] = tb_h[k];
            end
        end
        #1;
        chk("read", 32'(oRead), 32'(rd));
        if (oRead[0]) rd0_cnt++;
        if (oRead[2]) rd2_cnt++;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(640 + i, 0, 1'b0, (i >= 2 && i < 6), vs_drv);
    endtask

    task automatic line(input int y, input int x_lo, input int x_hi);
        for (int x = x_lo; x < x_hi; x++) step(x, y, 1'b1, 1'b0, vs_drv);
        blank(8);
    endtask

    task automatic frame_start();
        fs_drv = 1'b1;
        step(700, 500, 1'b0, 1'b0, 1'b1);
        fs_drv = 1'b0;
    endtask

    initial begin
        bg = {10'h3FF, 10'h000, 10'h000};
        iBG_COLOR = bg;
        tb_data[0] = 16'h001F; exp_col[0] = {10'h3E0, 10'h000, 10'h000};
        tb_data[1] = 16'hF800; exp_col[1] = {10'h000, 10'h000, 10'h3E0};
        tb_data[2] = 16'h07E0; exp_col[2] = {10'h000, 10'h3F0, 10'h000};
        tb_data[3] = 16'h1234; exp_col[3] = {10'h280, 10'h110, 10'h040};
        hv[0] = 1'b0; hv[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tb_en[k] = 0; tb_x0[k] = 0; tb_y0[k] = 0; tb_w[k] = 0; tb_h[k] = 0;
            sh_en[k] = 0; sh_x0[k] = 0; sh_y0[k] = 0; sh_w[k] = 0; sh_h[k] = 0;
        end
        iWIN_EN = '0; iWIN_X0 = '0; iWIN_Y0 = '0; iWIN_W = '0; iWIN_H = '0;
        iRD_DATA = '0; iRD_EMPTY = '0;

        // Reset, then raster with no shadow load: background only, no reads
        rst_drv = 1'b1;
        blank(3);
        rst_drv = 1'b0;
        vs_drv = 1'b1; blank(6); vs_drv = 1'b0;
        for (int y = 0; y < 3; y++) line(y, 0, 640);

        // Two side-by-side quadrants
        tb_en = '{1, 1, 0, 0};
        tb_x0 = '{0, 320, 0, 0}; tb_y0 = '{0, 0, 0, 0};
        tb_w  = '{320, 320, 0, 0}; tb_h = '{240, 240, 0, 0};
        apply_cfg();
        frame_start();
        line(0, 0, 640);
        line(239, 0, 640);
        line(240, 0, 640);

        // Mid-frame geometry change has no effect until the next frame pulse
        tb_x0[0] = 100;
        apply_cfg();
        line(10, 0, 640);
        frame_start();
        line(10, 0, 640);

        // Underflow on window 1, including an occluded read at x=350
        for (int x = 0; x < 640; x++) begin
            empty_drv = ((x >= 500 && x < 510) || x == 350) ? 4'b0010 : 4'b0000;
            step(x, 5, 1'b1, 1'b0, 1'b0);
        end
        empty_drv = '0;
        blank(3);
        clr_drv = 1'b1; blank(1); clr_drv = 1'b0;
        blank(3);
        // Clear coinciding with a new underflow: flag stays set
        clr_drv = 1'b1; empty_drv = 4'b0010;
        step(600, 5, 1'b1, 1'b0, 1'b0);
        clr_drv = 1'b0; empty_drv = '0;
        blank(3);
        clr_drv = 1'b1; blank(1); clr_drv = 1'b0;
        blank(3);

        // Overlap with priority; zero-width window never reads
        tb_en = '{1, 1, 1, 0};
        tb_x0 = '{100, 120, 120, 0}; tb_y0 = '{100, 120, 120, 0};
        tb_w  = '{50, 0, 50, 0};     tb_h  = '{50, 50, 50, 0};
        apply_cfg();
        frame_start();
        rd0_cnt = 0; rd2_cnt = 0;
        for (int y = 95; y < 175; y++) begin
            for (int x = 95; x < 175; x++) begin
                step(x, y, 1'b1, 1'b0, 1'b0);
                if (x == 130 && y == 130) chk("ovl_read", 32'(oRead), 32'h5);
            end
            blank(2);
        end
        chk("rd0_count", 32'(rd0_cnt), 32'd2500);
        chk("rd2_count", 32'(rd2_cnt), 32'd2500);

        // Small window on ch3 (border pixels white when the border option is built in)
        tb_en = '{0, 0, 0, 1};
        tb_x0 = '{0, 0, 0, 10}; tb_y0 = '{0, 0, 0, 10};
        tb_w  = '{0, 0, 0, 4};  tb_h  = '{0, 0, 0, 4};
        apply_cfg();
        frame_start();
        for (int y = 8; y < 16; y++) begin
            for (int x = 8; x < 16; x++) step(x, y, 1'b1, 1'b0, 1'b0);
            blank(2);
        end

        // Reset mid-line flushes the pipeline and clears the shadow windows
        for (int x = 0; x < 40; x++) begin
            rst_drv = (x >= 20 && x < 22);
            step(x, 12, 1'b1, 1'b0, 1'b0);
        end
        rst_drv = 1'b0;
        blank(4);
        line(12, 0, 40);
        blank(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
